// File: rtl/hello_world_stim_seq.sv
// rtl/hello_world_stim_seq.sv - eight-vector UUT stimulus sequencer with response capture and MISR signature
module hello_world_stim_seq #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [15:0] SEED          = 16'hFFFF
) (
  input  logic        bertaClock,
  input  logic        global_reset,
  input  logic        start,
  input  logic        abort,
  output logic [2:0]  x_out,
  input  logic [10:0] uut_out,
  output logic [2:0]  vec_idx,
  output logic        capture_valid,
  output logic [10:0] capture_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Settle counter counts down to zero, so the hold time is SETTLE_CYCLES cycles.
  localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [15:0] sig_next;

  // MISR step: CCITT-polynomial shift with the UUT response folded into the low bits
  always_comb begin
    sig_next = {signature[14:0], 1'b0}
             ^ (signature[15] ? 16'h1021 : 16'h0000)
             ^ {5'b0, uut_out};
  end

  // Sequencer: abort overrides everything, start only honoured from IDLE or DONE
  always_ff @(posedge bertaClock or negedge global_reset) begin
    if (!global_reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      x_out         <= 3'd0;
      vec_idx       <= 3'd0;
      capture_valid <= 1'b0;
      capture_data  <= 11'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      signature     <= SEED;
    end else begin
      capture_valid <= 1'b0;
      if (abort) begin
        // Signature is deliberately kept so a cancelled run can still be inspected.
        state   <= IDLE;
        x_out   <= 3'd0;
        vec_idx <= 3'd0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= SETTLE;
              cnt       <= CNT_RELOAD;
              x_out     <= 3'd0;
              vec_idx   <= 3'd0;
              signature <= SEED;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          SETTLE: begin
            if (cnt == 8'd0) begin
              state <= CAPTURE;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          CAPTURE: begin
            capture_data  <= uut_out;
            capture_valid <= 1'b1;
            signature     <= sig_next;
            if (vec_idx != 3'd7) begin
              state   <= SETTLE;
              cnt     <= CNT_RELOAD;
              vec_idx <= vec_idx + 3'd1;
              x_out   <= vec_idx + 3'd1;
            end else begin
              state <= DONE;
              x_out <= 3'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
